// File: rtl/uart_pin_arbiter.sv
// Two-requester arbiter for one physical UART pin pair.
// Ownership alternates and is handed over only after the line has idled for IDLE_CYCLES.
module uart_pin_arbiter #(
  parameter  int IDLE_CYCLES = 8680,
  localparam int CNT_W       = $clog2(IDLE_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  input  logic       tx0_i,
  input  logic       tx1_i,
  output logic       rx0_o,
  output logic       rx1_o,
  output logic       tx_o,
  input  logic       rx_i
);

  localparam logic [1:0]       ST_IDLE = 2'b00;
  localparam logic [1:0]       ST_OWN0 = 2'b01;
  localparam logic [1:0]       ST_OWN1 = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic             rx_s1, rx_s2;
  logic             own_tx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
    end
  end

  // Round-robin pick on a tie; owners leave only with their request low and a full guard.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        unique case (req_i)
          2'b01:   state_d = ST_OWN0;
          2'b10:   state_d = ST_OWN1;
          2'b11:   state_d = last_q ? ST_OWN0 : ST_OWN1;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_OWN0: if (!req_i[0] && cnt_q == CNT_MAX) state_d = ST_IDLE;
      ST_OWN1: if (!req_i[1] && cnt_q == CNT_MAX) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    own_tx = (state_q == ST_OWN1) ? tx1_i : tx0_i;
    last_d = last_q;
    if (state_q == ST_IDLE && state_d != ST_IDLE) last_d = state_d[1];

    // Guard counter: any low bit on either direction of the owned line restarts it.
    if (state_q == ST_IDLE)     cnt_d = '0;
    else if (own_tx && rx_s2)   cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    else                        cnt_d = '0;

    unique case (state_d)
      ST_OWN0: tx_d = tx0_i;
      ST_OWN1: tx_d = tx1_i;
      default: tx_d = 1'b1;
    endcase

    gnt_o = state_q;
    tx_o  = tx_q;
    rx0_o = (state_q == ST_OWN0) ? rx_s2 : 1'b1;
    rx1_o = (state_q == ST_OWN1) ? rx_s2 : 1'b1;
  end

endmodule

// File: tb/tb_uart_pin_arbiter.sv
// Bench for uart_pin_arbiter: fixed vectors, directed corner sequences and a
// randomized run compared against a behavioural model of ownership and idle time.
module tb_uart_pin_arbiter;
  localparam int IDLE = 8;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] req_i = 2'b11;
  logic       tx0_i = 1'b0, tx1_i = 1'b0, rx_i = 1'b1;
  logic [1:0] gnt_o;
  logic       rx0_o, rx1_o, tx_o;

  int checks = 0;
  int failures = 0;

  uart_pin_arbiter #(.IDLE_CYCLES(IDLE)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .tx0_i(tx0_i), .tx1_i(tx1_i), .rx0_o(rx0_o), .rx1_o(rx1_o),
    .tx_o(tx_o), .rx_i(rx_i)
  );

  always #5 clk = ~clk;

  // Model: who owns the pin, how long the owned line has been idle, what rx looks like 2 samples late.
  int owner = -1;
  bit last_owner = 1'b1;
  int idle_run = 0;
  bit m_tx = 1'b1;
  bit rx_hist1 = 1'b1, rx_hist2 = 1'b1;

  function automatic bit tx_of(int o);
    return (o == 0) ? tx0_i : tx1_i;
  endfunction

  task automatic model_step();
    int pick;
    bit release_now;
    if (rst_i) begin
      owner = -1; last_owner = 1'b1; idle_run = 0; m_tx = 1'b1;
      rx_hist1 = 1'b1; rx_hist2 = 1'b1;
    end else begin
      if (owner < 0) begin
        pick = -1;
        if (req_i == 2'b01) pick = 0;
        else if (req_i == 2'b10) pick = 1;
        else if (req_i == 2'b11) pick = last_owner ? 0 : 1;
        if (pick >= 0) begin
          owner = pick; last_owner = pick[0]; idle_run = 0; m_tx = tx_of(pick);
        end else m_tx = 1'b1;
      end else begin
        release_now = !req_i[owner] && idle_run >= IDLE;
        idle_run = (tx_of(owner) && rx_hist2) ? idle_run + 1 : 0;
        if (release_now) begin owner = -1; m_tx = 1'b1; end
        else m_tx = tx_of(owner);
      end
      rx_hist2 = rx_hist1;
      rx_hist1 = rx_i;
    end
  endtask

  task automatic check(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    logic [1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    check("model_gnt", gnt_o, eg);
    check("model_tx", {1'b0, tx_o}, {1'b0, m_tx});
    check("model_rx0", {1'b0, rx0_o}, {1'b0, (owner == 0) ? rx_hist2 : 1'b1});
    check("model_rx1", {1'b0, rx1_o}, {1'b0, (owner == 1) ? rx_hist2 : 1'b1});
  endtask

  task automatic wait_gnt(logic [1:0] want, int budget);
    int n = 0;
    while (gnt_o !== want && n < budget) begin cyc(); n++; end
    check("wait_gnt", gnt_o, want);
  endtask

  typedef struct {
    logic rst; logic [1:0] req; logic tx0, tx1, rx;
    logic [1:0] gnt; logic tx, rx0, rx1;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 12; i++) begin
      rst_i = tbl[i].rst; req_i = tbl[i].req;
      tx0_i = tbl[i].tx0; tx1_i = tbl[i].tx1; rx_i = tbl[i].rx;
      cyc();
      check($sformatf("vec%0d_gnt", i), gnt_o, tbl[i].gnt);
      check($sformatf("vec%0d_tx", i), {1'b0, tx_o}, {1'b0, tbl[i].tx});
      check($sformatf("vec%0d_rx0", i), {1'b0, rx0_o}, {1'b0, tbl[i].rx0});
      check($sformatf("vec%0d_rx1", i), {1'b0, rx1_o}, {1'b0, tbl[i].rx1});
    end

    // Release guard: tx0 rises at T, grant must hold through T+8 and drop at T+9.
    req_i = 2'b00; tx0_i = 1'b0; tx1_i = 1'b0; rx_i = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc(); check("guard_hold_low", gnt_o, 2'b01); end
    tx0_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check($sformatf("guard_k%0d", k), gnt_o, (k < 9) ? 2'b01 : 2'b00);
    end
    check("guard_tx_idle", {1'b0, tx_o}, 2'b01);

    // Guard restart: one-cycle rx glitch at count 5 pushes the release out.
    req_i = 2'b01; cyc(); check("restart_own", gnt_o, 2'b01);
    req_i = 2'b00;
    for (int i = 0; i < 5; i++) cyc();
    rx_i = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      rx_i = 1'b1;
      check($sformatf("restart_j%0d", j), gnt_o, (j < 12) ? 2'b01 : 2'b00);
    end

    // Round-robin with a single idle gap each way and no preemption.
    req_i = 2'b01; tx0_i = 1'b1; tx1_i = 1'b1; cyc(); check("rr_own0", gnt_o, 2'b01);
    req_i = 2'b11;
    for (int i = 0; i < 12; i++) begin cyc(); check("rr_hold0", gnt_o, 2'b01); end
    req_i = 2'b10; cyc(); check("rr_gap01", gnt_o, 2'b00);
    check("rr_gap_tx", {1'b0, tx_o}, 2'b01);
    cyc(); check("rr_own1", gnt_o, 2'b10);
    req_i = 2'b11;
    for (int i = 0; i < 12; i++) begin cyc(); check("rr_hold1", gnt_o, 2'b10); end
    req_i = 2'b01; cyc(); check("rr_gap10", gnt_o, 2'b00);
    cyc(); check("rr_back0", gnt_o, 2'b01);

    // Reset while requester 1 owns and drives low.
    req_i = 2'b10; wait_gnt(2'b10, 40);
    tx1_i = 1'b0; cyc(); check("mid_tx_low", {1'b0, tx_o}, 2'b00);
    rst_i = 1'b1; cyc();
    check("mid_rst_gnt", gnt_o, 2'b00);
    check("mid_rst_tx", {1'b0, tx_o}, 2'b01);
    rst_i = 1'b0; req_i = 2'b11; cyc(); check("mid_after_rst", gnt_o, 2'b01);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) req_i = 2'($urandom_range(0, 3));
      tx0_i = ($urandom_range(0, 11) != 0);
      tx1_i = ($urandom_range(0, 11) != 0);
      rx_i  = ($urandom_range(0, 15) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
